// File: rtl/id_stage_ctrl_pkg.sv
// Shared decode definitions for the ID stage: RV32I opcodes, immediate format select, NOP.
package id_stage_ctrl_pkg;

    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_NONE = 3'd5
    } imm_type_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

endpackage

// File: rtl/id_op_classify.sv
// id_op_classify: RV32I opcode -> immediate format, register usage, rd and load flag.
// ID_ILLEGAL_DETECT_EN: unknown opcodes are flagged illegal and their rd is forced to 0.
module id_op_classify
    import id_stage_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [4:0] i_rd_field,
    output imm_type_e  o_imm_type,
    output logic       o_rs1_used,
    output logic       o_rs2_used,
    output logic [4:0] o_rd,
    output logic       o_is_load,
    output logic       o_illegal
);

    always_comb begin
        o_imm_type = IMM_NONE;
        o_rs1_used = 1'b1;
        o_rs2_used = 1'b0;
        o_rd       = i_rd_field;
        o_is_load  = 1'b0;
        o_illegal  = 1'b0;
        case (i_opcode)
            OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: o_imm_type = IMM_I;
            OPC_LOAD: begin
                o_imm_type = IMM_I;
                o_is_load  = 1'b1;
            end
            OPC_STORE: begin
                o_imm_type = IMM_S;
                o_rs2_used = 1'b1;
                o_rd       = '0;
            end
            OPC_BRANCH: begin
                o_imm_type = IMM_B;
                o_rs2_used = 1'b1;
                o_rd       = '0;
            end
            OPC_LUI, OPC_AUIPC: begin
                o_imm_type = IMM_U;
                o_rs1_used = 1'b0;
            end
            OPC_JAL: begin
                o_imm_type = IMM_J;
                o_rs1_used = 1'b0;
            end
            OPC_OP: o_rs2_used = 1'b1;
            default: begin
`ifdef ID_ILLEGAL_DETECT_EN
                o_illegal = 1'b1;
                o_rd      = '0;
`endif
            end
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: IF/ID and ID/EX registers, handshake, load-use bubbles and flush for RV32I decode.
// ID_ILLEGAL_DETECT_EN (via id_op_classify) enables ex_illegal; otherwise it stays 0.
module id_stage_ctrl
    import id_stage_ctrl_pkg::*;
#(
    parameter int unsigned PC_WIDTH         = 32,
    parameter int unsigned LOAD_USE_BUBBLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_valid,
    input  logic [31:0]         if_inst,
    input  logic [PC_WIDTH-1:0] if_pc,
    output logic                if_ready,
    input  logic                flush,
    output logic [24:0]         imm_inst,
    output logic [2:0]          imm_type,
    input  logic [31:0]         imm_result,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [31:0]         ex_inst,
    output logic [PC_WIDTH-1:0] ex_pc,
    output logic [31:0]         ex_imm,
    output logic [4:0]          ex_rd,
    output logic                ex_is_load,
    output logic                ex_illegal
);

    localparam logic [1:0] BUBBLE_RELOAD = 2'(LOAD_USE_BUBBLES - 1);

    logic                r_id_valid;
    logic [31:0]         r_id_inst;
    logic [PC_WIDTH-1:0] r_id_pc;
    logic                r_ex_valid;
    logic [31:0]         r_ex_inst;
    logic [PC_WIDTH-1:0] r_ex_pc;
    logic [31:0]         r_ex_imm;
    logic [4:0]          r_ex_rd;
    logic                r_ex_is_load;
    logic                r_ex_illegal;
    logic [1:0]          r_bubble_cnt;

    imm_type_e  w_imm_type;
    logic       w_rs1_used;
    logic       w_rs2_used;
    logic [4:0] w_rd;
    logic       w_is_load;
    logic       w_illegal;
    logic       w_ex_free;
    logic       w_rs_hit;
    logic       w_direct_hazard;
    logic       w_hazard;
    logic       w_advance;
    logic       w_take;

    id_op_classify u_classify (
        .i_opcode   (r_id_inst[6:0]),
        .i_rd_field (r_id_inst[11:7]),
        .o_imm_type (w_imm_type),
        .o_rs1_used (w_rs1_used),
        .o_rs2_used (w_rs2_used),
        .o_rd       (w_rd),
        .o_is_load  (w_is_load),
        .o_illegal  (w_illegal)
    );

    assign w_ex_free       = !r_ex_valid || ex_ready;
    assign w_rs_hit        = (w_rs1_used && (r_id_inst[19:15] == r_ex_rd)) ||
                             (w_rs2_used && (r_id_inst[24:20] == r_ex_rd));
    assign w_direct_hazard = r_id_valid && r_ex_valid && r_ex_is_load &&
                             (r_ex_rd != '0) && w_rs_hit;
    // The counter covers the extra bubbles after the first one, once the load has left EX.
    assign w_hazard        = w_direct_hazard || (r_bubble_cnt != '0);
    assign w_advance       = r_id_valid && w_ex_free && !w_hazard;
    assign if_ready        = !r_id_valid || w_advance;
    assign w_take          = if_valid && if_ready;

    assign imm_inst = r_id_valid ? r_id_inst[31:7] : '0;
    assign imm_type = r_id_valid ? w_imm_type : IMM_NONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_valid   <= 1'b0;
            r_id_inst    <= '0;
            r_id_pc      <= '0;
            r_ex_valid   <= 1'b0;
            r_ex_inst    <= INST_NOP;
            r_ex_pc      <= '0;
            r_ex_imm     <= '0;
            r_ex_rd      <= '0;
            r_ex_is_load <= 1'b0;
            r_ex_illegal <= 1'b0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_id_valid   <= 1'b0;
            r_ex_valid   <= 1'b0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_take) begin
                r_id_valid <= 1'b1;
                r_id_inst  <= if_inst;
                r_id_pc    <= if_pc;
            end else if (w_advance) begin
                r_id_valid <= 1'b0;
            end

            if (w_advance) begin
                r_ex_valid   <= 1'b1;
                r_ex_inst    <= r_id_inst;
                r_ex_pc      <= r_id_pc;
                r_ex_imm     <= imm_result;
                r_ex_rd      <= w_rd;
                r_ex_is_load <= w_is_load;
                r_ex_illegal <= w_illegal;
            end else if (w_ex_free) begin
                r_ex_valid <= 1'b0;
            end

            if (w_direct_hazard) begin
                r_bubble_cnt <= BUBBLE_RELOAD;
            end else if ((r_bubble_cnt != '0) && w_ex_free) begin
                r_bubble_cnt <= r_bubble_cnt - 2'd1;
            end
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_inst    = r_ex_inst;
    assign ex_pc      = r_ex_pc;
    assign ex_imm     = r_ex_imm;
    assign ex_rd      = r_ex_rd;
    assign ex_is_load = r_ex_is_load;
    assign ex_illegal = r_ex_illegal;

endmodule
